// File: rtl/dac_cfg_shifter.sv
// Serial configuration sequencer: shifts one DATA_W-bit command LSB-first to a selected dac_driver.
// Optional macro DAC_CFG_BCAST_EN enables broadcast (all select lines) via cmd_bcast.
module dac_cfg_shifter #(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned NUM_CH    = 16,
    parameter int unsigned CH_W      = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HIGH_CYC  = 2,
    parameter int unsigned LOW_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_target,
    input  logic [CH_W-1:0]   cmd_chan,
    input  logic              cmd_bcast,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              sdata,
    output logic              cycle_count_clk,
    output logic              mask_clk,
    output logic [NUM_CH-1:0] select_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned BIT_W   = $clog2(DATA_W) + 1;
    localparam int unsigned MAX_A   = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > LOW_CYC) ? MAX_A : LOW_CYC;
    localparam int unsigned PH_W    = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_n;
    logic [PH_W-1:0]   ph_q, ph_n;
    logic [BIT_W-1:0]  bit_q, bit_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              tgt_q, tgt_n;
    logic [NUM_CH-1:0] sel_q, sel_n;

    logic              bcast_c;
    logic              chan_ok_c;
    logic              shifting_c;

`ifdef DAC_CFG_BCAST_EN
    assign bcast_c = cmd_bcast;
`else
    logic unused_bcast;
    assign unused_bcast = cmd_bcast;
    assign bcast_c      = 1'b0;
`endif

    assign chan_ok_c = ({1'b0, cmd_chan} < (CH_W + 1)'(NUM_CH));

    // Next-state, datapath and next-output logic; outputs are registered from these.
    always_comb begin
        state_n = state_q;
        ph_n    = ph_q + 1'b1;
        bit_n   = bit_q;
        data_n  = data_q;
        tgt_n   = tgt_q;
        sel_n   = sel_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    tgt_n  = cmd_target;
                    data_n = cmd_data;
                    bit_n  = '0;
                    if (bcast_c) begin
                        sel_n   = '1;
                        state_n = S_SETUP;
                    end else if (chan_ok_c) begin
                        sel_n   = NUM_CH'(1) << cmd_chan;
                        state_n = S_SETUP;
                    end else begin
                        sel_n   = '0;
                        state_n = S_ERR;
                    end
                end
            end
            S_SETUP: if (ph_q == PH_W'(SETUP_CYC - 1)) state_n = S_HIGH;
            S_HIGH:  if (ph_q == PH_W'(HIGH_CYC - 1))  state_n = S_LOW;
            S_LOW: begin
                if (ph_q == PH_W'(LOW_CYC - 1)) begin
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_SETUP;
                        bit_n   = bit_q + 1'b1;
                        data_n  = data_q >> 1;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (state_n != state_q || state_q == S_IDLE) ph_n = '0;
    end

    assign shifting_c = (state_n == S_SETUP) || (state_n == S_HIGH) || (state_n == S_LOW);

    // State, datapath and registered outputs; reset aborts any shift in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ph_q            <= '0;
            bit_q           <= '0;
            data_q          <= '0;
            tgt_q           <= 1'b0;
            sel_q           <= '0;
            sdata           <= 1'b0;
            cycle_count_clk <= 1'b0;
            mask_clk        <= 1'b0;
            select_out      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            cmd_ready       <= 1'b1;
        end else begin
            state_q         <= state_n;
            ph_q            <= ph_n;
            bit_q           <= bit_n;
            data_q          <= data_n;
            tgt_q           <= tgt_n;
            sel_q           <= sel_n;
            sdata           <= shifting_c & data_n[0];
            cycle_count_clk <= (state_n == S_HIGH) & ~tgt_n;
            mask_clk        <= (state_n == S_HIGH) & tgt_n;
            select_out      <= shifting_c ? sel_n : '0;
            busy            <= (state_n != S_IDLE);
            done            <= (state_n == S_DONE);
            err             <= (state_n == S_ERR);
            cmd_ready       <= (state_n == S_IDLE);
        end
    end

endmodule

// File: tb/tb_dac_cfg_shifter.sv
// Randomized self-checking bench for dac_cfg_shifter against a per-cycle waveform model.
// Honors DAC_CFG_BCAST_EN when deciding the expected broadcast select pattern.
module tb_dac_cfg_shifter;

    localparam int unsigned DW  = 8;
    localparam int unsigned NCH = 12;
    localparam int unsigned CHW = 4;
    localparam int unsigned SC  = 2;
    localparam int unsigned HC  = 2;
    localparam int unsigned LC  = 2;
    localparam int unsigned PER = SC + HC + LC;
    localparam int unsigned NB  = DW * PER;
    localparam int unsigned OW  = NCH + 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_target;
    logic [CHW-1:0] cmd_chan;
    logic           cmd_bcast;
    logic [DW-1:0]  cmd_data;
    logic           sdata;
    logic           cycle_count_clk;
    logic           mask_clk;
    logic [NCH-1:0] select_out;
    logic           busy;
    logic           done;
    logic           err;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dac_cfg_shifter #(
        .DATA_W(DW), .NUM_CH(NCH), .CH_W(CHW),
        .SETUP_CYC(SC), .HIGH_CYC(HC), .LOW_CYC(LC)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_chan(cmd_chan),
        .cmd_bcast(cmd_bcast), .cmd_data(cmd_data),
        .sdata(sdata), .cycle_count_clk(cycle_count_clk), .mask_clk(mask_clk),
        .select_out(select_out), .busy(busy), .done(done), .err(err)
    );

    // {select, sdata, cc_clk, mask_clk, busy, done, err, ready}
    function automatic logic [OW-1:0] observed();
        return {select_out, sdata, cycle_count_clk, mask_clk, busy, done, err, cmd_ready};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic tgt, input logic [CHW-1:0] ch, input logic bc,
                         input logic [DW-1:0] d);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        n_run++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid  = 1'b1;
        cmd_target = tgt;
        cmd_chan   = ch;
        cmd_bcast  = bc;
        cmd_data   = d;
        step();
        cmd_valid  = 1'b0;
        cmd_target = ~tgt;
        cmd_chan   = CHW'($urandom);
        cmd_data   = DW'($urandom);
    endtask

    // Called right after the accepting edge; walks the full shift, DONE and return to idle.
    task automatic test_shift(input string name, input logic tgt, input logic [NCH-1:0] sel,
                              input logic [DW-1:0] d);
        for (int k = 1; k <= int'(NB) + 2; k++) begin
            logic [OW-1:0] exp;
            logic [OW-1:0] obs;
            int            bitn;
            int            ph;
            logic          hi;
            if (k <= int'(NB)) begin
                bitn = (k - 1) / int'(PER);
                ph   = (k - 1) % int'(PER);
                hi   = (ph >= int'(SC)) && (ph < int'(SC + HC));
                exp  = {sel, d[bitn], hi & ~tgt, hi & tgt, 1'b1, 1'b0, 1'b0, 1'b0};
            end else if (k == int'(NB) + 1) begin
                exp = {NCH'(0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
            end else begin
                exp = {NCH'(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            end
            obs = observed();
            n_run++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s cycle T+%0d: got %b required %b", name, k, obs, exp);
            end
            if (k < int'(NB) + 2) step();
        end
    endtask

    task automatic test_reset();
        logic [OW-1:0] exp;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_target = 1'b0; cmd_chan = '0; cmd_bcast = 1'b0; cmd_data = '0;
        repeat (3) step();
        exp = {NCH'(0), 6'b0, 1'b1};
        n_run++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %b required %b", observed(), exp);
        end
        rst = 1'b0;
        step();
        n_run++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL reset_idle: got %b required %b", observed(), exp);
        end
    endtask

    task automatic test_cycle_count();
        issue(1'b0, 4'd3, 1'b0, 8'hA5);
        test_shift("cycle_count_a5", 1'b0, NCH'(12'h008), 8'hA5);
    endtask

    task automatic test_mask();
        issue(1'b1, 4'd11, 1'b0, 8'h01);
        test_shift("mask_01", 1'b1, NCH'(12'h800), 8'h01);
        issue(1'b1, 4'd0, 1'b0, 8'h80);
        test_shift("mask_80", 1'b1, NCH'(12'h001), 8'h80);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic          t;
            int            c;
            logic [DW-1:0] d;
            t = 1'(($urandom));
            c = int'($urandom_range(0, NCH - 1));
            d = DW'($urandom);
            issue(t, CHW'(c), 1'b0, d);
            test_shift("random", t, NCH'(1) << c, d);
        end
    endtask

    task automatic test_invalid();
        int bad [3] = '{12, 13, 15};
        foreach (bad[i]) begin
            logic [OW-1:0] exp;
            issue(1'b0, CHW'(bad[i]), 1'b0, DW'($urandom));
            exp = {NCH'(0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            n_run++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL invalid_err ch%0d: got %b required %b", bad[i], observed(), exp);
            end
            step();
            exp = {NCH'(0), 6'b0, 1'b1};
            n_run++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL invalid_recover ch%0d: got %b required %b", bad[i], observed(), exp);
            end
        end
        issue(1'b0, 4'd7, 1'b0, 8'h3C);
        test_shift("after_invalid", 1'b0, NCH'(12'h080), 8'h3C);
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] exp;
        issue(1'b1, 4'd5, 1'b0, 8'hFF);
        repeat (5 * PER + 2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp = {NCH'(0), 6'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            n_run++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got %b required %b", k, observed(), exp);
            end
            step();
        end
        issue(1'b0, 4'd2, 1'b0, 8'h96);
        test_shift("after_reset_mid", 1'b0, NCH'(12'h004), 8'h96);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        da = DW'($urandom);
        db = DW'($urandom);
        issue(1'b0, 4'd9, 1'b0, da);
        cmd_valid  = 1'b1;
        cmd_target = 1'b1;
        cmd_chan   = 4'd1;
        cmd_bcast  = 1'b0;
        cmd_data   = db;
        test_shift("b2b_first", 1'b0, NCH'(12'h200), da);
        step();
        cmd_valid = 1'b0;
        cmd_data  = ~db;
        test_shift("b2b_second", 1'b1, NCH'(12'h002), db);
    endtask

    task automatic test_bcast();
        logic [NCH-1:0] sel;
        logic [DW-1:0]  d;
`ifdef DAC_CFG_BCAST_EN
        sel = '1;
`else
        sel = NCH'(12'h001);
`endif
        d = DW'($urandom);
        issue(1'b1, 4'd0, 1'b1, d);
        cmd_bcast = 1'b0;
        test_shift("bcast", 1'b1, sel, d);
    endtask

    initial begin
        test_reset();
        test_cycle_count();
        test_mask();
        test_random();
        test_invalid();
        test_reset_mid();
        test_back_to_back();
        test_bcast();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", n_run, n_fail);
        $fatal(1, "timeout");
    end

endmodule
